// File: rtl/cmp_frame_collector.sv
// cmp_frame_collector: per-frame statistics over comparator results.
// Ports: clk, rst_n, start, in_valid/in_ready + a/b/a_larger/equal in; gt/eq/lt_cnt, max_val, out_valid/out_ready out; busy.
module cmp_frame_collector #(
  parameter int SIZE      = 8,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [SIZE-1:0]  a,
  input  logic [SIZE-1:0]  b,
  input  logic             a_larger,
  input  logic             equal,
  output logic             in_ready,
  output logic             busy,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [SIZE-1:0]  max_val,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] smp_cnt;
  logic             xfer;
  logic [SIZE-1:0]  ab_max;
  logic [SIZE-1:0]  nxt_max;

  assign xfer = in_valid && in_ready;

  // Local unsigned max; upstream flags are not trusted for this.
  always_comb begin
    ab_max  = (a > b) ? a : b;
    nxt_max = (ab_max > max_val) ? ab_max : max_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      smp_cnt   <= '0;
      gt_cnt    <= '0;
      eq_cnt    <= '0;
      lt_cnt    <= '0;
      max_val   <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= COLLECT;
            smp_cnt  <= '0;
            gt_cnt   <= '0;
            eq_cnt   <= '0;
            lt_cnt   <= '0;
            max_val  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        COLLECT: begin
          if (xfer) begin
            // equal wins over a_larger so bad
            // inputs are counted exactly once
            if (equal) begin
              eq_cnt <= eq_cnt + ONE;
            end else if (a_larger) begin
              gt_cnt <= gt_cnt + ONE;
            end else begin
              lt_cnt <= lt_cnt + ONE;
            end
            max_val <= nxt_max;
            smp_cnt <= smp_cnt + ONE;
            if (smp_cnt == LAST) begin
              state     <= REPORT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        REPORT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_frame_collector.sv
// tb_cmp_frame_collector: directed bench with result scoreboard.
// Ports: none; drives cmp_frame_collector with FRAME_LEN=4.
module tb_cmp_frame_collector;

  localparam int SIZE = 8;
  localparam int FL   = 4;
  localparam int CW   = 5;

  typedef struct {
    int gt;
    int eq;
    int lt;
    int mx;
  } res_t;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            in_valid;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            a_larger;
  logic            equal;
  logic            in_ready;
  logic            busy;
  logic [CW-1:0]   gt_cnt;
  logic [CW-1:0]   eq_cnt;
  logic [CW-1:0]   lt_cnt;
  logic [SIZE-1:0] max_val;
  logic            out_valid;
  logic            out_ready;

  int   n_vec;
  int   n_bad;
  res_t exp_q[$];

  cmp_frame_collector #(
    .SIZE(SIZE), .FRAME_LEN(FL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .a(a), .b(b),
    .a_larger(a_larger), .equal(equal),
    .in_ready(in_ready), .busy(busy),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt),
    .lt_cnt(lt_cnt), .max_val(max_val),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Monitor: pops one expected frame per result handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("sb_gt", int'(gt_cnt), e.gt);
        check("sb_eq", int'(eq_cnt), e.eq);
        check("sb_lt", int'(lt_cnt), e.lt);
        check("sb_max", int'(max_val), e.mx);
        check("sb_sum",
              int'(gt_cnt) + int'(eq_cnt) + int'(lt_cnt), FL);
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the transfer edge.
  task automatic send(input int av, input int bv,
                      input bit al, input bit eq);
    bit done;
    done     = 1'b0;
    a        = SIZE'(av);
    b        = SIZE'(bv);
    a_larger = al;
    equal    = eq;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after the final transfer edge.
  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_out_valid", int'(out_valid), 0);
    check("drain_busy", int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    a_larger  = 1'b0;
    equal     = 1'b0;
    out_ready = 1'b0;
    #12;
    rst_n = 1'b1;

    // Idle with in_valid high: nothing moves
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = 8'd9;
    b = 8'd3;
    a_larger = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_in_ready", int'(in_ready), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_out_valid", int'(out_valid), 0);
    check("idle_gt", int'(gt_cnt), 0);
    check("idle_max", int'(max_val), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Frame A: back-to-back
    exp_q.push_back('{2, 1, 1, 255});
    do_start();
    send(218, 165, 1, 0);
    send(170, 170, 0, 1);
    send(51, 85, 0, 0);
    check("a_pre_last_ov", int'(out_valid), 0);
    send(255, 0, 1, 0);
    check("a_out_valid", int'(out_valid), 1);
    check("a_in_ready", int'(in_ready), 0);
    drain();

    // Frame B: gaps between transfers
    exp_q.push_back('{1, 1, 2, 204});
    do_start();
    check("b_cleared_gt", int'(gt_cnt), 0);
    check("b_cleared_max", int'(max_val), 0);
    send(85, 204, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("b_gap_lt", int'(lt_cnt), 1);
    check("b_gap_max", int'(max_val), 204);
    send(51, 85, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("b_gap_lt2", int'(lt_cnt), 2);
    send(10, 10, 0, 1);
    send(3, 2, 1, 0);

    // Hold in REPORT with start/in_valid pulses
    for (int i = 0; i < 5; i++) begin
      start    = i[0];
      in_valid = ~i[0];
      @(negedge clk);
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_gt", int'(gt_cnt), 1);
      check("hold_lt", int'(lt_cnt), 2);
      check("hold_max", int'(max_val), 204);
      @(posedge clk);
      #1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    check("idle_keep_lt", int'(lt_cnt), 2);
    @(posedge clk);
    #1;

    // Frame C: inconsistent flags on (7,7)
    exp_q.push_back('{1, 2, 1, 9});
    do_start();
    check("c_clear_lt", int'(lt_cnt), 0);
    check("c_busy", int'(busy), 1);
    send(7, 7, 1, 1);
    check("c_incons_eq", int'(eq_cnt), 1);
    check("c_incons_gt", int'(gt_cnt), 0);
    send(1, 2, 0, 0);
    send(9, 3, 1, 0);
    send(4, 4, 0, 1);
    drain();

    // Async reset mid-frame
    do_start();
    send(100, 50, 1, 0);
    send(60, 60, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_gt", int'(gt_cnt), 0);
    check("rst_eq", int'(eq_cnt), 0);
    check("rst_max", int'(max_val), 0);
    check("rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame D: full frame after reset
    exp_q.push_back('{2, 1, 1, 201});
    do_start();
    send(200, 201, 0, 0);
    send(0, 0, 0, 1);
    send(128, 127, 1, 0);
    send(90, 30, 1, 0);
    drain();

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
